// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
//   Round-robin arbiter that shares one ahb_master user interface among NREQ
//   requesters. One requester is granted at a time. Its burst is sequenced onto
//   the i* outputs as a NONSEQ beat followed by SEQ beats. HREADY/HRESP are
//   tracked to count beats. Read data and done/err status go back to the
//   granted requester.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   INCR_MAX  beat cap for undefined-length INCR bursts
//   PROT      constant driven on iHPROT
//
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   req/req_write/req_lock  per-requester request, direction, locked access
//   req_addr/req_wdata      per-requester 32-bit slices
//   req_burst/req_size      per-requester 3-bit slices (HBURST/HSIZE encodings)
//   HREADY, HRESP, HRDATA   slave response as seen by ahb_master
//   gnt                     one-hot grant
//   beat_ack                address phase accepted; requester advances req_wdata
//   rdata_valid, rdata      registered read beat
//   done, err               one-cycle completion / abort pulses
//   iHTRANS..iHWRITE        ahb_master user interface
module ahb_rr_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         INCR_MAX = 16,
  parameter logic [3:0] PROT     = 4'h1
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_write,
  input  logic [NREQ*32-1:0]  req_addr,
  input  logic [NREQ*3-1:0]   req_burst,
  input  logic [NREQ*3-1:0]   req_size,
  input  logic [NREQ-1:0]     req_lock,
  input  logic [NREQ*32-1:0]  req_wdata,
  input  logic                HREADY,
  input  logic                HRESP,
  input  logic [31:0]         HRDATA,
  output logic [NREQ-1:0]     gnt,
  output logic                beat_ack,
  output logic                rdata_valid,
  output logic [31:0]         rdata,
  output logic                done,
  output logic                err,
  output logic [1:0]          iHTRANS,
  output logic [2:0]          iHBURST,
  output logic [2:0]          iHSIZE,
  output logic [3:0]          iHPROT,
  output logic                iHMASTLOCK,
  output logic [31:0]         iHADDR,
  output logic [31:0]         iHWDATA,
  output logic                iHWRITE
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0]      INCR_CAP = 5'(INCR_MAX);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_ARB, ST_ADDR, ST_SEQ, ST_DATA} state_t;

  state_t r_state, w_state_nxt;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [NREQ-1:0] r_gnt;
  logic [31:0]     r_addr;
  logic [2:0]      r_burst;
  logic [2:0]      r_size;
  logic            r_write;
  logic            r_lock;
  logic            r_incr;
  logic [4:0]      r_beats;
  logic [4:0]      r_cnt;
  logic            r_done;
  logic            r_err;
  logic            r_rvalid;
  logic [31:0]     r_rdata;

  logic [31:0] w_addr_a  [NREQ];
  logic [31:0] w_wdata_a [NREQ];
  logic [2:0]  w_burst_a [NREQ];
  logic [2:0]  w_size_a  [NREQ];

  logic [PW-1:0] w_win;
  logic          w_found;
  logic          w_abort;
  logic          w_greq;
  logic          w_load;
  logic [PW-1:0] w_load_idx;
  logic          w_release;
  logic          w_cnt_first;
  logic          w_cnt_inc;
  logic          w_rd_cap;
  logic          w_done_set;
  logic          w_err_set;

  function automatic logic [4:0] f_beats(input logic [2:0] burst);
    logic [4:0] b;
    case (burst)
      3'b000:         b = 5'd1;
      3'b001:         b = INCR_CAP;
      3'b010, 3'b011: b = 5'd4;
      3'b100, 3'b101: b = 5'd8;
      default:        b = 5'd16;
    endcase
    return b;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_addr_a[gi]  = req_addr[32*gi +: 32];
    assign w_wdata_a[gi] = req_wdata[32*gi +: 32];
    assign w_burst_a[gi] = req_burst[3*gi +: 3];
    assign w_size_a[gi]  = req_size[3*gi +: 3];
  end

  // Winner: first asserted request searching upward from ptr+1, wrapping.
  always_comb begin
    int k;
    k       = 0;
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(r_ptr) + i) % NREQ;
      if (!w_found && req[PW'(k)]) begin
        w_win   = PW'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_abort = HRESP & ~HREADY;
  assign w_greq  = req[r_gidx];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    iHTRANS     = TR_IDLE;
    beat_ack    = 1'b0;
    w_load      = 1'b0;
    w_load_idx  = w_win;
    w_release   = 1'b0;
    w_cnt_first = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rd_cap    = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_abort) begin
          w_err_set   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_ARB;
        end else begin
          iHTRANS = TR_NONSEQ;
          if (HREADY) begin
            beat_ack    = 1'b1;
            w_cnt_first = 1'b1;
            w_state_nxt = (r_beats > 5'd1) ? ST_SEQ : ST_DATA;
          end
        end
      end
      ST_SEQ: begin
        if (w_abort) begin
          w_err_set   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_ARB;
        end else begin
          // HREADY here completes the previous beat's data phase.
          w_rd_cap = HREADY & ~r_write;
          if (r_incr && !w_greq) begin
            // Undefined-length burst ended by the requester: no further beat.
            w_state_nxt = ST_DATA;
          end else begin
            iHTRANS = TR_SEQ;
            if (HREADY) begin
              beat_ack  = 1'b1;
              w_cnt_inc = 1'b1;
              if (r_cnt + 5'd1 == r_beats) w_state_nxt = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (w_abort) begin
          w_err_set   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_ARB;
        end else if (HREADY) begin
          w_rd_cap   = ~r_write;
          w_done_set = 1'b1;
          if (r_lock && w_greq) begin
            // Locked requester keeps the bus: reload its descriptor, skip ARB.
            w_load      = 1'b1;
            w_load_idx  = r_gidx;
            w_state_nxt = ST_ADDR;
          end else begin
            w_release   = 1'b1;
            w_state_nxt = ST_ARB;
          end
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ptr    <= PW'(NREQ - 1);
      r_gidx   <= '0;
      r_gnt    <= '0;
      r_addr   <= '0;
      r_burst  <= '0;
      r_size   <= 3'b010;
      r_write  <= 1'b0;
      r_lock   <= 1'b0;
      r_incr   <= 1'b0;
      r_beats  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done   <= w_done_set;
      r_err    <= w_err_set;
      r_rvalid <= w_rd_cap;
      if (w_rd_cap) r_rdata <= HRDATA;

      if (w_load) begin
        r_gidx  <= w_load_idx;
        r_ptr   <= w_load_idx;
        r_gnt   <= ONE_HOT0 << w_load_idx;
        r_addr  <= w_addr_a[w_load_idx];
        r_burst <= w_burst_a[w_load_idx];
        r_size  <= w_size_a[w_load_idx];
        r_write <= req_write[w_load_idx];
        r_lock  <= req_lock[w_load_idx];
        r_incr  <= (w_burst_a[w_load_idx] == 3'b001);
        r_beats <= f_beats(w_burst_a[w_load_idx]);
      end else if (w_release) begin
        r_gnt  <= '0;
        r_lock <= 1'b0;
      end

      if (w_cnt_first)    r_cnt <= 5'd1;
      else if (w_cnt_inc) r_cnt <= r_cnt + 5'd1;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign err         = r_err;
  assign rdata_valid = r_rvalid;
  assign rdata       = r_rdata;
  assign iHBURST     = r_burst;
  assign iHSIZE      = r_size;
  assign iHPROT      = PROT;
  assign iHMASTLOCK  = r_lock;
  assign iHADDR      = r_addr;
  assign iHWRITE     = r_write;
  assign iHWDATA     = (|r_gnt) ? w_wdata_a[r_gidx] : 32'h0;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter
//   Directed bench for ahb_rr_arbiter (NREQ=4): reset, round-robin order,
//   stalled write burst, wrapping read burst, error abort, locked back-to-back
//   bursts and reset in the middle of a burst.
module tb_ahb_rr_arbiter;

  logic         HCLK;
  logic         HRESET;
  logic [3:0]   req, req_write, req_lock;
  logic [127:0] req_addr, req_wdata;
  logic [11:0]  req_burst, req_size;
  logic         HREADY, HRESP;
  logic [31:0]  HRDATA;
  logic [3:0]   gnt;
  logic         beat_ack, rdata_valid, done, err;
  logic [31:0]  rdata;
  logic [1:0]   iHTRANS;
  logic [2:0]   iHBURST, iHSIZE;
  logic [3:0]   iHPROT;
  logic         iHMASTLOCK, iHWRITE;
  logic [31:0]  iHADDR, iHWDATA;

  logic [31:0] a_addr  [4];
  logic [31:0] a_wdata [4];
  logic [2:0]  a_burst [4];
  logic [2:0]  a_size  [4];

  assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};
  assign req_burst = {a_burst[3], a_burst[2], a_burst[1], a_burst[0]};
  assign req_size  = {a_size[3], a_size[2], a_size[1], a_size[0]};

  int n_tests = 0;
  int n_fail  = 0;

  ahb_rr_arbiter #(.NREQ(4), .INCR_MAX(16), .PROT(4'h1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_burst(req_burst), .req_size(req_size), .req_lock(req_lock),
    .req_wdata(req_wdata),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .gnt(gnt), .beat_ack(beat_ack), .rdata_valid(rdata_valid), .rdata(rdata),
    .done(done), .err(err),
    .iHTRANS(iHTRANS), .iHBURST(iHBURST), .iHSIZE(iHSIZE), .iHPROT(iHPROT),
    .iHMASTLOCK(iHMASTLOCK), .iHADDR(iHADDR), .iHWDATA(iHWDATA), .iHWRITE(iHWRITE)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge HCLK);
    #2;
  endtask

  task automatic set_desc(input int k, input logic [31:0] a, input logic [2:0] b,
                          input logic [31:0] wd);
    a_addr[k]  = a;
    a_burst[k] = b;
    a_size[k]  = 3'b010;
    a_wdata[k] = wd;
  endtask

  int acks, dones, errs, rvs;
  int hr3 [6];
  int tr3 [6];
  int g6  [14];
  int t6  [14];
  int d6  [14];
  int l6  [14];

  initial begin
    HRESET = 1'b1;
    req = '0; req_write = '0; req_lock = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    for (int k = 0; k < 4; k++) set_desc(k, 32'h0, 3'b000, 32'h0);

    // ---------------- reset state ----------------
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_htrans", 32'(iHTRANS), 32'h0);
    chk("rst_hprot", 32'(iHPROT), 32'h1);
    chk("rst_hsize", 32'(iHSIZE), 32'h2);
    chk("rst_haddr", iHADDR, 32'h0);
    chk("rst_hwdata", iHWDATA, 32'h0);
    chk("rst_lock", 32'(iHMASTLOCK), 32'h0);
    chk("rst_done_err_rv", {29'h0, done, err, rdata_valid}, 32'h0);
    cyc();
    cyc();
    HRESET = 1'b0;

    // ---------------- round robin, SINGLE bursts ----------------
    cyc();
    req = 4'b1111;
    #1;
    chk("t2_arb_htrans", 32'(iHTRANS), 32'h0);
    chk("t2_arb_gnt", 32'(gnt), 32'h0);
    for (int n = 0; n < 5; n++) begin
      cyc(); #1;
      chk($sformatf("t2_addr_gnt_%0d", n), 32'(gnt), 32'h1 << (n % 4));
      chk($sformatf("t2_addr_trans_%0d", n), 32'(iHTRANS), 32'h2);
      chk($sformatf("t2_addr_ack_%0d", n), 32'(beat_ack), 32'h1);
      cyc(); #1;
      chk($sformatf("t2_data_gnt_%0d", n), 32'(gnt), 32'h1 << (n % 4));
      chk($sformatf("t2_data_trans_%0d", n), 32'(iHTRANS), 32'h0);
      chk($sformatf("t2_data_done_%0d", n), 32'(done), 32'h0);
      cyc();
      if (n == 4) req = 4'b0000;
      #1;
      chk($sformatf("t2_arb_gnt_%0d", n), 32'(gnt), 32'h0);
      chk($sformatf("t2_arb_done_%0d", n), 32'(done), 32'h1);
    end

    // ---------------- INCR4 write, stall on beat 2 ----------------
    hr3 = '{1, 1, 0, 0, 1, 1};
    tr3 = '{2, 3, 3, 3, 3, 3};
    cyc();
    set_desc(0, 32'h100, 3'b011, 32'hA0);
    req_write = 4'b0001;
    req = 4'b0001;
    #1;
    chk("t3_arb_trans", 32'(iHTRANS), 32'h0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      HREADY = hr3[i][0];
      #1;
      if (i == 0) begin
        chk("t3_gnt", 32'(gnt), 32'h1);
        chk("t3_haddr", iHADDR, 32'h100);
        chk("t3_hburst", 32'(iHBURST), 32'h3);
        chk("t3_hwrite", 32'(iHWRITE), 32'h1);
        chk("t3_hwdata", iHWDATA, 32'hA0);
      end
      chk($sformatf("t3_trans_%0d", i), 32'(iHTRANS), 32'(tr3[i]));
      chk($sformatf("t3_ack_%0d", i), 32'(beat_ack), 32'(hr3[i]));
      acks += int'(beat_ack);
    end
    cyc();
    HREADY = 1'b1;
    #1;
    chk("t3_data_trans", 32'(iHTRANS), 32'h0);
    chk("t3_data_done", 32'(done), 32'h0);
    cyc();
    req = 4'b0000;
    #1;
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_gnt_clr", 32'(gnt), 32'h0);
    chk("t3_ack_count", 32'(acks), 32'd4);
    cyc(); #1;
    chk("t3_done_once", 32'(done), 32'h0);

    // ---------------- WRAP8 read by req1 ----------------
    cyc();
    set_desc(1, 32'h3C, 3'b100, 32'h0);
    req_write = 4'b0000;
    req = 4'b0010;
    #1;
    chk("t4_arb_trans", 32'(iHTRANS), 32'h0);
    rvs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      HRDATA = 32'hD000_0000 + 32'(i);
      if (i == 9) req = 4'b0000;
      #1;
      if (i == 0) begin
        chk("t4_gnt", 32'(gnt), 32'h2);
        chk("t4_haddr", iHADDR, 32'h3C);
        chk("t4_hburst", 32'(iHBURST), 32'h4);
      end
      chk($sformatf("t4_trans_%0d", i), 32'(iHTRANS),
          (i == 0) ? 32'h2 : (i <= 7) ? 32'h3 : 32'h0);
      chk($sformatf("t4_rv_%0d", i), 32'(rdata_valid), (i >= 2) ? 32'h1 : 32'h0);
      if (i >= 2)
        chk($sformatf("t4_rdata_%0d", i), rdata, 32'hD000_0000 + 32'(i - 1));
      rvs += int'(rdata_valid);
      if (i == 8) chk("t4_done_early", 32'(done), 32'h0);
      if (i == 9) chk("t4_done", 32'(done), 32'h1);
    end
    chk("t4_rv_count", 32'(rvs), 32'd8);

    // ---------------- INCR16 aborted by ERROR on beat 3 ----------------
    cyc();
    set_desc(2, 32'h200, 3'b111, 32'h0);
    set_desc(3, 32'h300, 3'b000, 32'h0);
    req = 4'b1100;
    #1;
    chk("t5_arb_trans", 32'(iHTRANS), 32'h0);
    cyc(); #1;
    chk("t5_gnt2", 32'(gnt), 32'h4);
    chk("t5_b1_trans", 32'(iHTRANS), 32'h2);
    cyc(); #1;
    chk("t5_b2_trans", 32'(iHTRANS), 32'h3);
    chk("t5_b2_ack", 32'(beat_ack), 32'h1);
    cyc();
    HREADY = 1'b0; HRESP = 1'b1;
    #1;
    chk("t5_err_trans_idle", 32'(iHTRANS), 32'h0);
    chk("t5_err_noack", 32'(beat_ack), 32'h0);
    chk("t5_err_not_yet", 32'(err), 32'h0);
    cyc();
    HREADY = 1'b1; HRESP = 1'b0;
    req = 4'b1000;
    #1;
    chk("t5_err_pulse", 32'(err), 32'h1);
    chk("t5_no_done", 32'(done), 32'h0);
    chk("t5_gnt_clr", 32'(gnt), 32'h0);
    cyc(); #1;
    chk("t5_gnt3", 32'(gnt), 32'h8);
    chk("t5_g3_haddr", iHADDR, 32'h300);
    chk("t5_err_once", 32'(err), 32'h0);
    cyc(); #1;
    chk("t5_g3_data_done", 32'(done), 32'h0);
    cyc();
    req = 4'b0000;
    #1;
    chk("t5_g3_done", 32'(done), 32'h1);
    chk("t5_g3_noerr", 32'(err), 32'h0);

    // ---------------- locked back-to-back INCR4, req0 pending ----------------
    g6 = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0, 1, 1, 0};
    t6 = '{2, 3, 3, 3, 0, 2, 3, 3, 3, 0, 0, 2, 0, 0};
    d6 = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    l6 = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    cyc();
    set_desc(2, 32'h400, 3'b011, 32'hB2);
    set_desc(0, 32'h500, 3'b000, 32'hB0);
    req_write = 4'b0101;
    req_lock = 4'b0100;
    req = 4'b0100;
    #1;
    chk("t6_arb_trans", 32'(iHTRANS), 32'h0);
    acks = 0;
    dones = 0;
    for (int j = 0; j < 14; j++) begin
      cyc();
      if (j == 0) req = 4'b0101;
      if (j == 9) req = 4'b0001;
      if (j == 13) req = 4'b0000;
      #1;
      chk($sformatf("t6_gnt_%0d", j), 32'(gnt), 32'(g6[j]));
      chk($sformatf("t6_trans_%0d", j), 32'(iHTRANS), 32'(t6[j]));
      chk($sformatf("t6_done_%0d", j), 32'(done), 32'(d6[j]));
      chk($sformatf("t6_lock_%0d", j), 32'(iHMASTLOCK), 32'(l6[j]));
      if (j <= 9) acks += int'(beat_ack);
      dones += int'(done);
    end
    chk("t6_ack_count", 32'(acks), 32'd8);
    chk("t6_done_count", 32'(dones), 32'd3);
    req_lock = 4'b0000;

    // ---------------- reset in the middle of INCR8 ----------------
    cyc();
    set_desc(0, 32'h600, 3'b101, 32'h0);
    set_desc(1, 32'h700, 3'b000, 32'h0);
    req_write = 4'b0000;
    req = 4'b0001;
    #1;
    chk("t1_arb_trans", 32'(iHTRANS), 32'h0);
    cyc(); #1;
    chk("t1_addr_trans", 32'(iHTRANS), 32'h2);
    cyc(); #1;
    chk("t1_seq_trans", 32'(iHTRANS), 32'h3);
    cyc();
    HRESET = 1'b1;
    req = 4'b0011;
    #1;
    chk("t1_rst_gnt", 32'(gnt), 32'h0);
    chk("t1_rst_trans", 32'(iHTRANS), 32'h0);
    chk("t1_rst_ack", 32'(beat_ack), 32'h0);
    chk("t1_rst_haddr", iHADDR, 32'h0);
    chk("t1_rst_hsize", 32'(iHSIZE), 32'h2);
    cyc();
    HRESET = 1'b0;
    #1;
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_trans", 32'(iHTRANS), 32'h0);
    cyc(); #1;
    chk("t1_first_gnt_req0", 32'(gnt), 32'h1);
    chk("t1_first_trans", 32'(iHTRANS), 32'h2);
    chk("t1_first_haddr", iHADDR, 32'h600);
    errs = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
